frame_mem_arbiter: RTL and testbench

//  Shares one frame-memory write port between two frame writers: req0 = accepted
//  (checksum-OK) frames, req1 = rejected (FAIL) frames. Grants one writer a whole

---
 rtl/frame_mem_arbiter_if.sv | 54 +++++
 rtl/frame_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_frame_mem_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// frame_mem_arbiter_if
//   Bundles every non-clock/reset signal of frame_mem_arbiter: the two frame
//   writer requests and lengths, the shared buffer read port, the frame-memory
//   write port and the completion/status outputs.
//
//   modport master : the arbiter (drives grants, read address, memory port,
//                    done/byte/busy; receives requests, lengths, read data)
//   modport slave  : the surroundings (frame writers, their buffers, the BRAM)
//
//   Signal summary
//     i_req[1:0]     frame-ready request per writer, held until o_done
//     i_len0/1       frame length per writer, sampled at grant
//     o_gnt[1:0]     one-hot grant, grant through o_done inclusive
//     o_rd_addr      byte index into the granted writer's buffer
//     i_rd_data0/1   buffer read data, one cycle after o_rd_addr
//     o_mem_en/wen   memory enable / write strobe (always equal)
//     o_mem_waddr    bank base + byte index, wraps modulo 2^ADDR_W
//     o_mem_wdata    byte being written
//     o_done[1:0]    one-cycle pulse on the finished writer's bit
//     o_byte         bytes written by the last transfer, held
//     o_busy         arbiter not idle
// ---------------------------------------------------------------------------
interface frame_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic [1:0]        i_req;
  logic [ADDR_W-1:0] i_len0;
  logic [ADDR_W-1:0] i_len1;
  logic [1:0]        o_gnt;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data0;
  logic [DATA_W-1:0] i_rd_data1;
  logic              o_mem_en;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_waddr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [1:0]        o_done;
  logic [ADDR_W-1:0] o_byte;
  logic              o_busy;

  modport master (
    input  i_req, i_len0, i_len1, i_rd_data0, i_rd_data1,
    output o_gnt, o_rd_addr, o_mem_en, o_mem_wen, o_mem_waddr, o_mem_wdata,
           o_done, o_byte, o_busy
  );

  modport slave (
    output i_req, i_len0, i_len1, i_rd_data0, i_rd_data1,
    input  o_gnt, o_rd_addr, o_mem_en, o_mem_wen, o_mem_waddr, o_mem_wdata,
           o_done, o_byte, o_busy
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// ---------------------------------------------------------------------------
// frame_mem_arbiter
//   Shares one frame-memory write port between two frame writers. Writer 0
//   carries accepted frames, writer 1 rejected frames. A writer is granted a
//   whole frame; its bytes are fetched through its buffer read port (1-cycle
//   latency) and written contiguously starting at that writer's bank base
//   (0 for writer 0, BANK1_BASE for writer 1). When both request, the writer
//   that was not granted last wins; after reset writer 0 is favoured.
//
//   Ports
//     i_clk    single clock, rising edge
//     i_reset  synchronous, active-high; aborts a transfer immediately
//     bus      frame_mem_arbiter_if.master (requests, read port, write port,
//              done/byte/busy status)
//
//   Timing (decision cycle D = IDLE cycle that sees the request)
//     D+1 .. D+len     o_rd_addr = 0 .. len-1          (XFER)
//     D+3 .. D+len+2   o_mem_wen, waddr = base + idx    (last two in DRAIN)
//     D+len+3          o_done pulse, o_byte = len       (DONE)
//   A zero-length frame goes IDLE -> DONE, o_done at D+1 with no write.
// ---------------------------------------------------------------------------
module frame_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int BANK1_BASE = 512,
  parameter int MAX_LEN    = 512
) (
  input  logic                i_clk,
  input  logic                i_reset,
  frame_mem_arbiter_if.master bus
);

  localparam logic [ADDR_W-1:0] BANK1_BASE_W = ADDR_W'(BANK1_BASE);
  localparam logic [ADDR_W-1:0] MAX_LEN_W    = ADDR_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] ONE_W        = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Registered outputs
  logic [1:0]        gnt_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] byte_q;

  // Transfer context
  logic [ADDR_W-1:0] r_len;       // clamped frame length of current grant
  logic              r_drain;     // second DRAIN cycle marker
  logic              prefer1;     // writer 1 wins a tie (writer 0 granted last)

  // Read pipeline: address issued last cycle, its data is on i_rd_dataN now
  logic              rd_vld;
  logic [ADDR_W-1:0] rd_idx;

  // Arbitration for the IDLE decision
  logic              win1;
  logic [ADDR_W-1:0] win_len_raw;
  logic [ADDR_W-1:0] win_len;
  logic              last_addr;

  assign win1        = bus.i_req[1] & (~bus.i_req[0] | prefer1);
  assign win_len_raw = win1 ? bus.i_len1 : bus.i_len0;
  assign win_len     = (win_len_raw > MAX_LEN_W) ? MAX_LEN_W : win_len_raw;
  assign last_addr   = (rd_addr_q == r_len - ONE_W);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: state elements use non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:  if (bus.i_req != 2'b00) state_next = (win_len == '0) ? DONE : XFER;
      XFER:  if (last_addr)          state_next = DRAIN;
      DRAIN: if (r_drain)            state_next = DONE;
      DONE:                          state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      gnt_q     <= '0;
      rd_addr_q <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      byte_q    <= '0;
      r_len     <= '0;
      r_drain   <= 1'b0;
      prefer1   <= 1'b0;
      rd_vld    <= 1'b0;
      rd_idx    <= '0;
    end else begin
      // Read pipeline runs in every state; it only carries valid beats
      // while addresses are being issued in XFER.
      rd_vld <= (state == XFER);
      rd_idx <= rd_addr_q;

      // Write stage: data for the index issued last cycle is on the read port.
      wen_q <= rd_vld;
      if (rd_vld) begin
        waddr_q <= (gnt_q[1] ? BANK1_BASE_W : '0) + rd_idx;
        wdata_q <= gnt_q[1] ? bus.i_rd_data1 : bus.i_rd_data0;
      end

      unique case (state)
        IDLE: begin
          if (bus.i_req != 2'b00) begin
            gnt_q     <= win1 ? 2'b10 : 2'b01;
            r_len     <= win_len;
            rd_addr_q <= '0;
            r_drain   <= 1'b0;
            if (win_len == '0) byte_q <= '0;
          end
        end
        XFER: begin
          if (!last_addr) rd_addr_q <= rd_addr_q + ONE_W;
        end
        DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) byte_q <= r_len;
        end
        DONE: begin
          gnt_q   <= '0;
          prefer1 <= gnt_q[0];
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.o_gnt       = gnt_q;
  assign bus.o_rd_addr   = rd_addr_q;
  assign bus.o_mem_wen   = wen_q;
  assign bus.o_mem_en    = wen_q;
  assign bus.o_mem_waddr = waddr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_done      = (state == DONE) ? gnt_q : 2'b00;
  assign bus.o_byte      = byte_q;
  assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frame_mem_arbiter
//   Table of frame requests with expected completion order, byte counts and
//   latency; a write scoreboard fed from the bench's own buffer contents
//   checks every memory write; hand sequences cover reset mid-transfer and a
//   request held across o_done.
// ---------------------------------------------------------------------------
module tb_frame_mem_arbiter;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int BANK1_BASE = 512;
  localparam int MAX_LEN    = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  frame_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANK1_BASE(BANK1_BASE), .MAX_LEN(MAX_LEN)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Writer buffers with 1-cycle read latency
  logic [DATA_W-1:0] buf0 [1024];
  logic [DATA_W-1:0] buf1 [1024];
  always @(posedge clk) begin
    bus.i_rd_data0 <= buf0[bus.o_rd_addr];
    bus.i_rd_data1 <= buf1[bus.o_rd_addr];
  end

  // Write scoreboard
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  function automatic int clamp_len(input int len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  task automatic push_frame(input int w, input int len);
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < clamp_len(len); i++) begin
      a = ADDR_W'((w == 1 ? BANK1_BASE : 0) + i);
      exp_q.push_back('{addr: a, data: (w == 1) ? buf1[i] : buf0[i]});
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (bus.o_mem_en || bus.o_mem_wen) check("mem_en_eq_wen", bus.o_mem_en, bus.o_mem_wen);
      if (bus.o_mem_wen) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("waddr", bus.o_mem_waddr, e.addr);
          check("wdata", bus.o_mem_wdata, e.data);
        end
      end
    end
  end

  task automatic wait_done(output logic [1:0] d, output int cyc);
    d = 2'b00;
    cyc = 0;
    while (d == 2'b00 && cyc < 2000) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      d = bus.o_done;
    end
    if (d == 2'b00) check("done_timeout", cyc, 0);
  endtask

  typedef struct {
    logic [1:0] req;
    int         len0;
    int         len1;
    logic [1:0] done_a;
    int         byte_a;
    logic [1:0] done_b;   // 0 when only one frame completes
    int         byte_b;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] d;
    int cyc;
    bus.i_len0 = ADDR_W'(v.len0);
    bus.i_len1 = ADDR_W'(v.len1);
    push_frame(v.done_a[1] ? 1 : 0, v.done_a[1] ? v.len1 : v.len0);
    bus.i_req = v.req;
    wait_done(d, cyc);
    check($sformatf("v%0d_done_a", idx), d, v.done_a);
    check($sformatf("v%0d_byte_a", idx), bus.o_byte, v.byte_a);
    check($sformatf("v%0d_gnt_a", idx), bus.o_gnt, v.done_a);
    if (v.byte_a == 0) check($sformatf("v%0d_lat0_a", idx), cyc <= 2, 1);
    else               check($sformatf("v%0d_lat_a", idx), cyc, v.byte_a + 3);
    check($sformatf("v%0d_writes_left_a", idx), exp_q.size(), 0);
    bus.i_req = bus.i_req & ~d;
    if (v.done_b != 2'b00) begin
      push_frame(v.done_b[1] ? 1 : 0, v.done_b[1] ? v.len1 : v.len0);
      wait_done(d, cyc);
      check($sformatf("v%0d_done_b", idx), d, v.done_b);
      check($sformatf("v%0d_byte_b", idx), bus.o_byte, v.byte_b);
      check($sformatf("v%0d_lat_b", idx), cyc, (v.byte_b == 0) ? 2 : v.byte_b + 4);
      check($sformatf("v%0d_writes_left_b", idx), exp_q.size(), 0);
      bus.i_req = bus.i_req & ~d;
    end
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_gnt_clear", idx), bus.o_gnt, 0);
    check($sformatf("v%0d_busy_clear", idx), bus.o_busy, 0);
    check($sformatf("v%0d_byte_held", idx), bus.o_byte, (v.done_b != 2'b00) ? v.byte_b : v.byte_a);
  endtask

  vec_t vecs[8];

  initial begin
    logic [1:0] d;
    int cyc;
    int wseen;

    for (int i = 0; i < 1024; i++) begin
      buf0[i] = DATA_W'($urandom);
      buf1[i] = DATA_W'($urandom);
    end
    buf0[0] = 8'h30; buf0[1] = 8'h31; buf0[2] = 8'h04; buf0[3] = 8'h32;

    //          req    len0 len1 done_a byte_a done_b byte_b
    vecs[0] = '{2'b11, 3,   2,   2'b01, 3,     2'b10, 2};   // tie from reset
    vecs[1] = '{2'b01, 4,   0,   2'b01, 4,     2'b00, 0};   // 30 31 04 32
    vecs[2] = '{2'b11, 5,   6,   2'b10, 6,     2'b01, 5};   // req0 last -> req1
    vecs[3] = '{2'b10, 0,   3,   2'b10, 3,     2'b00, 0};   // bank 1: 512..514
    vecs[4] = '{2'b01, 0,   0,   2'b01, 0,     2'b00, 0};   // zero length
    vecs[5] = '{2'b01, 700, 0,   2'b01, 512,   2'b00, 0};   // clamped
    vecs[6] = '{2'b10, 0,   1,   2'b10, 1,     2'b00, 0};   // single byte
    vecs[7] = '{2'b11, 2,   0,   2'b01, 2,     2'b10, 0};   // req1 last -> req0

    reset = 1'b1;
    bus.i_req = 2'b00;
    bus.i_len0 = '0;
    bus.i_len1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_gnt",   bus.o_gnt, 0);
    check("rst_wen",   bus.o_mem_wen, 0);
    check("rst_en",    bus.o_mem_en, 0);
    check("rst_done",  bus.o_done, 0);
    check("rst_busy",  bus.o_busy, 0);
    check("rst_byte",  bus.o_byte, 0);
    check("rst_raddr", bus.o_rd_addr, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Request held across o_done is a fresh frame
    bus.i_len0 = ADDR_W'(2);
    push_frame(0, 2);
    bus.i_req = 2'b01;
    wait_done(d, cyc);
    check("held_done1", d, 2'b01);
    check("held_lat1", cyc, 5);
    push_frame(0, 2);
    wait_done(d, cyc);
    check("held_done2", d, 2'b01);
    check("held_lat2", cyc, 6);
    bus.i_req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    check("held_writes_left", exp_q.size(), 0);

    // Reset during the third write of an 8-byte frame
    bus.i_len0 = ADDR_W'(8);
    push_frame(0, 8);
    bus.i_req = 2'b01;
    wseen = 0;
    cyc = 0;
    while (wseen < 3 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.o_mem_wen) wseen++;
    end
    check("third_write_seen", wseen, 3);
    reset = 1'b1;
    bus.i_req = 2'b00;
    @(posedge clk);
    #1;
    exp_q.delete();
    check("abort_gnt",   bus.o_gnt, 0);
    check("abort_wen",   bus.o_mem_wen, 0);
    check("abort_done",  bus.o_done, 0);
    check("abort_busy",  bus.o_busy, 0);
    check("abort_byte",  bus.o_byte, 0);
    check("abort_waddr", bus.o_mem_waddr, 0);
    check("abort_raddr", bus.o_rd_addr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("post_abort_quiet", {bus.o_done, bus.o_mem_wen}, 0);
    end
    @(negedge clk);
    run_vec('{2'b01, 8, 0, 2'b01, 8, 2'b00, 0}, 8);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
